clken_scheduler: RTL

//  Sequences the CPU and sound clock-enable strobes derived from clk_sys. It

---
 rtl/clken_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/clken_scheduler.sv
// CPU and sound clock-enable scheduler for the clk_sys domain.
// Runtime-loadable divisors, pause/ack handshake and single-step of one CPU period.
module clken_scheduler #(
  parameter int DIV_W   = 8,
  parameter int CPU_DIV = 10,
  parameter int SND_DIV = 56
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] cpu_div,
  input  logic [DIV_W-1:0] snd_div,
  input  logic             div_load,
  input  logic             pause_req,
  output logic             pause_ack,
  input  logic             step,
  input  logic             snd_mute_on_pause,
  output logic             cpu_ce,
  output logic             snd_ce
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PAUSED,
    ST_STEP
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0] cpu_cnt, snd_cnt;
  logic [DIV_W-1:0] cpu_div_act, snd_div_act;
  logic [DIV_W-1:0] cpu_div_shd, snd_div_shd;
  logic             cpu_pend, snd_pend;
  logic             cpu_run, cpu_term;
  logic             snd_freeze, snd_term;

  // A divisor below 2 would make ce high on consecutive cycles.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  always_comb begin
    cpu_run    = (state != ST_PAUSED);
    cpu_term   = cpu_run && (cpu_cnt == cpu_div_act - DIV_W'(1));
    snd_freeze = snd_mute_on_pause && ((state == ST_PAUSED) || (state == ST_STEP));
    snd_term   = !snd_freeze && (snd_cnt == snd_div_act - DIV_W'(1));
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:    if (pause_req) state_next = ST_DRAIN;
      ST_DRAIN:  if (!pause_req) state_next = ST_RUN;
                 else if (cpu_term) state_next = ST_PAUSED;
      ST_PAUSED: if (!pause_req) state_next = ST_RUN;
                 else if (step) state_next = ST_STEP;
      ST_STEP:   if (cpu_term) state_next = pause_req ? ST_PAUSED : ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      pause_ack <= 1'b0;
    end else begin
      state     <= state_next;
      pause_ack <= (state == ST_PAUSED);
    end
  end

  // NOTE: every register here, shadows included, has an async reset value; none are left uninitialised.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_cnt     <= '0;
      cpu_ce      <= 1'b0;
      cpu_div_act <= DIV_W'(CPU_DIV);
      cpu_div_shd <= '0;
      cpu_pend    <= 1'b0;
    end else begin
      if (div_load) begin
        cpu_div_shd <= clamp_div(cpu_div);
        cpu_pend    <= 1'b1;
      end else if (cpu_term) begin
        cpu_pend    <= 1'b0;
      end
      if (cpu_term) begin
        cpu_cnt <= '0;
        cpu_ce  <= 1'b1;
        if (cpu_pend) cpu_div_act <= cpu_div_shd;
      end else begin
        cpu_ce  <= 1'b0;
        cpu_cnt <= cpu_run ? cpu_cnt + DIV_W'(1) : '0;
      end
    end
  end

  // Sound counter holds its value (not cleared) while muted during pause/step.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      snd_cnt     <= '0;
      snd_ce      <= 1'b0;
      snd_div_act <= DIV_W'(SND_DIV);
      snd_div_shd <= '0;
      snd_pend    <= 1'b0;
    end else begin
      if (div_load) begin
        snd_div_shd <= clamp_div(snd_div);
        snd_pend    <= 1'b1;
      end else if (snd_term) begin
        snd_pend    <= 1'b0;
      end
      if (snd_term) begin
        snd_cnt <= '0;
        snd_ce  <= 1'b1;
        if (snd_pend) snd_div_act <= snd_div_shd;
      end else begin
        snd_ce  <= 1'b0;
        if (!snd_freeze) snd_cnt <= snd_cnt + DIV_W'(1);
      end
    end
  end

endmodule
